// File: rtl/ex_div.sv
// ex_div: iterative 32-bit restoring divider for the execute stage.
// Handles div.w / div.wu / mod.w / mod.wu and holds the pipeline via stall_o
// until the result is ready. Optional build macro DIV_EARLY_OUT_EN retires
// divide-by-zero and |a| < |b| operations straight from IDLE.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start_i; latches operands, magnitudes and signs
// CALC  | one restoring-division step per cycle, DATA_WIDTH steps total
// FIX   | sign correction, divide-by-zero override, quotient/remainder select
// DONE  | result_valid_o pulse; always returns to IDLE
module ex_div #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_i,
   input  logic                      cancel_i,
   input  logic                      signed_i,
   input  logic                      op_mod_i,
   input  logic [DATA_WIDTH-1:0]     a_i,
   input  logic [DATA_WIDTH-1:0]     b_i,
   input  logic [REG_ADDR_WIDTH-1:0] wd_i,
   output logic                      stall_o,
   output logic                      result_valid_o,
   output logic [DATA_WIDTH-1:0]     result_o,
   output logic [REG_ADDR_WIDTH-1:0] wd_o
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [DATA_WIDTH:0]       rem_q, rem_d;       // one spare bit keeps the trial subtract from overflowing
   logic [DATA_WIDTH-1:0]     dvd_q, dvd_d;       // dividend shifts out, quotient shifts in
   logic [DATA_WIDTH-1:0]     dvs_q, dvs_d;
   logic [DATA_WIDTH-1:0]     a_raw_q, a_raw_d;   // original dividend, returned as remainder on /0
   logic                      b_zero_q, b_zero_d;
   logic                      qsign_q, qsign_d;
   logic                      rsign_q, rsign_d;
   logic                      mod_q, mod_d;
   logic [REG_ADDR_WIDTH-1:0] wd_lat_q, wd_lat_d;
   logic [DATA_WIDTH-1:0]     result_q, result_d;
   logic [REG_ADDR_WIDTH-1:0] wd_q, wd_d;
   logic                      valid_q, valid_d;

   logic                      a_neg, b_neg;
   logic [DATA_WIDTH-1:0]     abs_a, abs_b;
   logic [DATA_WIDTH+1:0]     shift_w;
   logic [DATA_WIDTH:0]       diff_w;
   logic                      no_borrow;
   logic [DATA_WIDTH-1:0]     q_fix, r_fix;

   // magnitudes are only taken for the signed variants
   assign a_neg = signed_i & a_i[DATA_WIDTH-1];
   assign b_neg = signed_i & b_i[DATA_WIDTH-1];
   assign abs_a = a_neg ? -a_i : a_i;
   assign abs_b = b_neg ? -b_i : b_i;

   // restoring step: the top bit of shift_w only matters for the compare
   assign shift_w   = {rem_q, dvd_q[DATA_WIDTH-1]};
   assign no_borrow = shift_w >= {2'b00, dvs_q};
   assign diff_w    = shift_w[DATA_WIDTH:0] - {1'b0, dvs_q};

   assign q_fix = qsign_q ? -dvd_q : dvd_q;
   assign r_fix = rsign_q ? -rem_q[DATA_WIDTH-1:0] : rem_q[DATA_WIDTH-1:0];

`ifdef DIV_EARLY_OUT_EN
   logic                  early_w;
   logic [DATA_WIDTH-1:0] early_res_w;
   assign early_w     = (b_i == '0) || (abs_a < abs_b);
   assign early_res_w = op_mod_i ? a_i : ((b_i == '0) ? '1 : '0);
`endif

   // next-state and datapath update for every register
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      a_raw_d  = a_raw_q;
      b_zero_d = b_zero_q;
      qsign_d  = qsign_q;
      rsign_d  = rsign_q;
      mod_d    = mod_q;
      wd_lat_d = wd_lat_q;
      result_d = result_q;
      wd_d     = wd_q;
      valid_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i && !cancel_i) begin
               state_d  = CALC;
               cnt_d    = '0;
               rem_d    = '0;
               dvd_d    = abs_a;
               dvs_d    = abs_b;
               a_raw_d  = a_i;
               b_zero_d = (b_i == '0);
               qsign_d  = signed_i & (a_i[DATA_WIDTH-1] ^ b_i[DATA_WIDTH-1]);
               rsign_d  = signed_i & a_i[DATA_WIDTH-1];
               mod_d    = op_mod_i;
               wd_lat_d = wd_i;
`ifdef DIV_EARLY_OUT_EN
               if (early_w) begin
                  state_d  = DONE;
                  result_d = early_res_w;
                  wd_d     = wd_i;
                  valid_d  = 1'b1;
               end
`endif
            end
         end
         CALC: begin
            rem_d = no_borrow ? diff_w : shift_w[DATA_WIDTH:0];
            dvd_d = {dvd_q[DATA_WIDTH-2:0], no_borrow};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = FIX;
            end
         end
         FIX: begin
            if (b_zero_q) begin
               result_d = mod_q ? a_raw_q : '1;
            end else begin
               result_d = mod_q ? r_fix : q_fix;
            end
            wd_d    = wd_lat_q;
            valid_d = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // a flush wins over everything, including a start in the same cycle
      if (cancel_i) begin
         state_d  = IDLE;
         valid_d  = 1'b0;
         result_d = result_q;
         wd_d     = wd_q;
      end
   end

   // register all state; synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         a_raw_q  <= '0;
         b_zero_q <= 1'b0;
         qsign_q  <= 1'b0;
         rsign_q  <= 1'b0;
         mod_q    <= 1'b0;
         wd_lat_q <= '0;
         result_q <= '0;
         wd_q     <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         a_raw_q  <= a_raw_d;
         b_zero_q <= b_zero_d;
         qsign_q  <= qsign_d;
         rsign_q  <= rsign_d;
         mod_q    <= mod_d;
         wd_lat_q <= wd_lat_d;
         result_q <= result_d;
         wd_q     <= wd_d;
         valid_q  <= valid_d;
      end
   end

   // stall drops in DONE so ID/EX can advance past the finished instruction
   assign stall_o        = start_i && (state_q != DONE);
   assign result_valid_o = valid_q;
   assign result_o       = result_q;
   assign wd_o           = wd_q;

endmodule
